// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode, funct and ALU encodings for the multicycle controller.
package ctrl_pkg;
    typedef logic [3:0] state_t;

    localparam state_t IDLE   = 4'd0;
    localparam state_t FETCH  = 4'd1;
    localparam state_t DECODE = 4'd2;
    localparam state_t EXEC   = 4'd3;
    localparam state_t MEMRD  = 4'd4;
    localparam state_t MEMWR  = 4'd5;
    localparam state_t BRANCH = 4'd6;
    localparam state_t JUMP   = 4'd7;
    localparam state_t HALT   = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath/memory signal bundle; master is the controller side.
interface mc_controller_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        irwrite;
    logic        pc_en;
    logic        memtoreg;
    logic        pcsrc;
    logic        alusrc;
    logic        regdst;
    logic        regwrite;
    logic        jump;
    logic [3:0]  alucontrol;
    logic        halted;
    logic        bus_err;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, irwrite, pc_en, memtoreg, pcsrc, alusrc,
               regdst, regwrite, jump, alucontrol, halted, bus_err
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, irwrite, pc_en, memtoreg, pcsrc, alusrc,
               regdst, regwrite, jump, alucontrol, halted, bus_err
    );
endinterface

// File: rtl/ctrl_alu_dec.sv
// ctrl_alu_dec: R-type funct to ALU operation, flagging unsupported functs.
module ctrl_alu_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alucontrol_o,
    output logic       funct_valid_o
);
    always_comb begin
        alucontrol_o  = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alucontrol_o = ALU_ADD;
            FN_SUB:  alucontrol_o = ALU_SUB;
            FN_AND:  alucontrol_o = ALU_AND;
            FN_OR:   alucontrol_o = ALU_OR;
            FN_SLT:  alucontrol_o = ALU_SLT;
            default: funct_valid_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM with req/ready memory handshake, watchdog and sticky halt.
// Define CTRL_RETIRE_CNT_EN to add the 32-bit retired-instruction counter output.
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    state_t        state_q, state_d, decode_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;
    logic [5:0]    op;
    logic [3:0]    alu_r;
    logic          funct_valid, is_r, wait_st, timeout;
    logic          unused_instr;

    ctrl_alu_dec u_alu_dec (
        .funct_i      (bus.instr[5:0]),
        .alucontrol_o (alu_r),
        .funct_valid_o(funct_valid)
    );

    assign op           = bus.instr[31:26];
    assign unused_instr = ^bus.instr[25:6];
    assign is_r         = op == OP_RTYPE;
    assign wait_st      = state_q inside {FETCH, MEMRD, MEMWR};
    // Timeout fires on the MEM_TIMEOUT-th consecutive ready-low cycle, so a late ready still wins.
    assign timeout      = MEM_TIMEOUT != 0 && wait_st && !bus.mem_ready && cnt_q == CNT_LAST;
    assign cnt_d        = wait_st && !bus.mem_ready ? cnt_q + 1'b1 : '0;
    assign bus_err_d    = bus_err_q | timeout;

    assign decode_next = is_r           ? (funct_valid ? EXEC : HALT) :
                         op == OP_ADDI  ? EXEC   :
                         op == OP_LW    ? MEMRD  :
                         op == OP_SW    ? MEMWR  :
                         op == OP_BEQ   ? BRANCH :
                         op == OP_J     ? JUMP   : HALT;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:                state_d = FETCH;
            FETCH:               state_d = bus.mem_ready ? DECODE : (timeout ? HALT : FETCH);
            DECODE:              state_d = decode_next;
            EXEC, BRANCH, JUMP:  state_d = FETCH;
            MEMRD, MEMWR:        state_d = bus.mem_ready ? FETCH : (timeout ? HALT : state_q);
            default:             state_d = HALT;
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pc_en      = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.pcsrc      = 1'b0;
        bus.alusrc     = 1'b0;
        bus.regdst     = 1'b0;
        bus.regwrite   = 1'b0;
        bus.jump       = 1'b0;
        bus.alucontrol = 4'b0000;
        case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.irwrite = bus.mem_ready;
            end
            EXEC: begin
                bus.regdst     = is_r;
                bus.alusrc     = !is_r;
                bus.regwrite   = 1'b1;
                bus.pc_en      = 1'b1;
                bus.alucontrol = is_r ? alu_r : ALU_ADD;
            end
            MEMRD, MEMWR: begin
                bus.mem_req    = 1'b1;
                bus.mem_we     = state_q == MEMWR;
                bus.alusrc     = 1'b1;
                bus.alucontrol = ALU_ADD;
                bus.memtoreg   = state_q == MEMRD && bus.mem_ready;
                bus.regwrite   = state_q == MEMRD && bus.mem_ready;
                bus.pc_en      = bus.mem_ready;
            end
            BRANCH: begin
                bus.alucontrol = ALU_SUB;
                bus.pcsrc      = bus.zero;
                bus.pc_en      = 1'b1;
            end
            JUMP: begin
                bus.jump  = 1'b1;
                bus.pc_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.halted  = state_q == HALT;
    assign bus.bus_err = bus_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;
    assign retired_d = retired_q + {31'd0, bus.pc_en};
    assign retired   = retired_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vector table plus randomized instruction stream against a per-instruction cycle model.
module tb_mc_controller;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_controller_if bus();
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    mc_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retired(retired)
`endif
    );

    typedef struct packed {
        logic req, we, irw, pc_en, m2r, pcsrc, alusrc, regdst, regwrite, jump, halted, bus_err;
        logic [3:0] alu;
    } ov_t;

    typedef struct {
        logic [31:0] instr;
        int          wf;
        int          wm;
        logic        z;
        int          len;
        logic [3:0]  alu;
        logic        pcsrc;
        string       name;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_ret = 0;
    vec_t tv[$];

    function automatic vec_t mk(logic [31:0] ins, int wf, int wm, logic z, int len,
                                logic [3:0] alu, logic pcsrc, string nm);
        vec_t v;
        v.instr = ins; v.wf = wf; v.wm = wm; v.z = z;
        v.len = len; v.alu = alu; v.pcsrc = pcsrc; v.name = nm;
        return v;
    endfunction

    function automatic ov_t sample();
        ov_t a;
        a.req = bus.mem_req; a.we = bus.mem_we; a.irw = bus.irwrite; a.pc_en = bus.pc_en;
        a.m2r = bus.memtoreg; a.pcsrc = bus.pcsrc; a.alusrc = bus.alusrc; a.regdst = bus.regdst;
        a.regwrite = bus.regwrite; a.jump = bus.jump; a.halted = bus.halted;
        a.bus_err = bus.bus_err; a.alu = bus.alucontrol;
        return a;
    endfunction

    // {valid, alucontrol} for an R-type funct
    function automatic logic [4:0] fn_map(logic [5:0] fn);
        case (fn)
            6'h20:   return 5'b1_0010;
            6'h22:   return 5'b1_0110;
            6'h24:   return 5'b1_0000;
            6'h25:   return 5'b1_0001;
            6'h2A:   return 5'b1_0111;
            default: return 5'b0_0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic z, input ov_t e, input string nm, output ov_t a);
        bus.mem_ready = rdy;
        bus.zero = z;
        @(negedge clk);
        a = sample();
        chk(nm, 32'(a), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        ov_t a;
        reset = 1'b1;
        #1;
        a = sample();
        chk({nm, "_in_reset"}, 32'(a), 32'd0);
        exp_ret = 0;
`ifdef CTRL_RETIRE_CNT_EN
        chk({nm, "_retired_rst"}, retired, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, '0, {nm, "_idle"}, a);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic z,
                             input string nm, output int hit, output logic [3:0] hit_alu,
                             output logic hit_pcsrc);
        ov_t q[$];
        logic r[$];
        ov_t e, base, a;
        logic [5:0] op;
        logic [4:0] fm;
        op = ins[31:26];
        fm = fn_map(ins[5:0]);
        bus.instr = ins;
        for (int i = 0; i < (wf < TO ? wf : TO); i++) begin
            e = '0; e.req = 1'b1; q.push_back(e); r.push_back(1'b0);
        end
        if (wf >= TO) begin
            e = '0; e.halted = 1'b1; e.bus_err = 1'b1;
            repeat (2) begin q.push_back(e); r.push_back(1'b1); end
        end else begin
            e = '0; e.req = 1'b1; e.irw = 1'b1; q.push_back(e); r.push_back(1'b1);
            q.push_back('0); r.push_back(1'b1);
            e = '0;
            if (op == 6'h00 && fm[4]) begin
                e.regdst = 1'b1; e.regwrite = 1'b1; e.pc_en = 1'b1; e.alu = fm[3:0];
                q.push_back(e); r.push_back(1'b1);
            end else if (op == 6'h08) begin
                e.alusrc = 1'b1; e.regwrite = 1'b1; e.pc_en = 1'b1; e.alu = 4'b0010;
                q.push_back(e); r.push_back(1'b1);
            end else if (op == 6'h04) begin
                e.alu = 4'b0110; e.pcsrc = z; e.pc_en = 1'b1;
                q.push_back(e); r.push_back(1'b1);
            end else if (op == 6'h02) begin
                e.jump = 1'b1; e.pc_en = 1'b1;
                q.push_back(e); r.push_back(1'b1);
            end else if (op == 6'h23 || op == 6'h2B) begin
                base = '0; base.req = 1'b1; base.we = op == 6'h2B; base.alusrc = 1'b1; base.alu = 4'b0010;
                for (int i = 0; i < (wm < TO ? wm : TO); i++) begin
                    q.push_back(base); r.push_back(1'b0);
                end
                if (wm >= TO) begin
                    e = '0; e.halted = 1'b1; e.bus_err = 1'b1;
                    repeat (2) begin q.push_back(e); r.push_back(1'b1); end
                end else begin
                    e = base; e.pc_en = 1'b1;
                    if (op == 6'h23) begin e.m2r = 1'b1; e.regwrite = 1'b1; end
                    q.push_back(e); r.push_back(1'b1);
                end
            end else begin
                e.halted = 1'b1;
                repeat (2) begin q.push_back(e); r.push_back(1'b1); end
            end
        end
        hit = 0; hit_alu = '0; hit_pcsrc = 1'b0;
        foreach (q[i]) begin
            step(r[i], z, q[i], $sformatf("%s_c%0d", nm, i + 1), a);
            if (hit == 0 && (a.pc_en || a.halted)) begin
                hit = i + 1; hit_alu = a.alu; hit_pcsrc = a.pcsrc;
            end
            if (q[i].pc_en) exp_ret++;
        end
`ifdef CTRL_RETIRE_CNT_EN
        chk({nm, "_retired"}, retired, exp_ret);
`endif
        if (q[q.size() - 1].halted) do_reset({nm, "_rel"});
    endtask

    initial begin
        int hit;
        logic [3:0] ha;
        logic hp;
        ov_t a, e;
        vec_t v;
        tv.push_back(mk(32'h012A4020, 0, 0, 1'b0, 3, 4'b0010, 1'b0, "add"));
        tv.push_back(mk(32'h012A4022, 0, 0, 1'b0, 3, 4'b0110, 1'b0, "sub"));
        tv.push_back(mk(32'h012A4024, 0, 0, 1'b0, 3, 4'b0000, 1'b0, "and"));
        tv.push_back(mk(32'h012A4025, 0, 0, 1'b0, 3, 4'b0001, 1'b0, "or"));
        tv.push_back(mk(32'h012A402A, 0, 0, 1'b0, 3, 4'b0111, 1'b0, "slt"));
        tv.push_back(mk(32'h21090005, 0, 0, 1'b0, 3, 4'b0010, 1'b0, "addi"));
        tv.push_back(mk(32'h8D090004, 0, 0, 1'b0, 3, 4'b0010, 1'b0, "lw0"));
        tv.push_back(mk(32'h8D090004, 0, 3, 1'b0, 6, 4'b0010, 1'b0, "lw_w3"));
        tv.push_back(mk(32'hAD090004, 0, 0, 1'b0, 3, 4'b0010, 1'b0, "sw0"));
        tv.push_back(mk(32'hAD090004, 0, 3, 1'b0, 6, 4'b0010, 1'b0, "sw_rdy4th"));
        tv.push_back(mk(32'hAD090004, 0, 4, 1'b0, 7, 4'b0000, 1'b0, "sw_timeout"));
        tv.push_back(mk(32'h8D090004, 0, 9, 1'b0, 7, 4'b0000, 1'b0, "lw_timeout"));
        tv.push_back(mk(32'h11090003, 0, 0, 1'b1, 3, 4'b0110, 1'b1, "beq_z1"));
        tv.push_back(mk(32'h11090003, 0, 0, 1'b0, 3, 4'b0110, 1'b0, "beq_z0"));
        tv.push_back(mk(32'h08000010, 0, 0, 1'b0, 3, 4'b0000, 1'b0, "j"));
        tv.push_back(mk(32'h012A4020, 2, 0, 1'b0, 5, 4'b0010, 1'b0, "add_fwait2"));
        tv.push_back(mk(32'h012A4020, 4, 0, 1'b0, 5, 4'b0000, 1'b0, "fetch_timeout"));
        tv.push_back(mk(32'hFC000000, 0, 0, 1'b0, 3, 4'b0000, 1'b0, "illegal_op"));
        tv.push_back(mk(32'h012A403F, 0, 0, 1'b0, 3, 4'b0000, 1'b0, "bad_funct"));

        bus.instr = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");

        foreach (tv[i]) begin
            run_instr(tv[i].instr, tv[i].wf, tv[i].wm, tv[i].z, tv[i].name, hit, ha, hp);
            chk({tv[i].name, "_len"}, hit, tv[i].len);
            chk({tv[i].name, "_alu"}, 32'(ha), 32'(tv[i].alu));
            chk({tv[i].name, "_pcsrc"}, 32'(hp), 32'(tv[i].pcsrc));
        end

        // reset in the middle of a load's memory wait
        bus.instr = 32'h8D090004;
        e = '0; e.req = 1'b1; e.irw = 1'b1;
        step(1'b1, 1'b0, e, "mid_fetch", a);
        step(1'b1, 1'b0, '0, "mid_decode", a);
        e = '0; e.req = 1'b1; e.alusrc = 1'b1; e.alu = 4'b0010;
        step(1'b0, 1'b0, e, "mid_memrd1", a);
        step(1'b0, 1'b0, e, "mid_memrd2", a);
        do_reset("mid_rst");
        run_instr(32'h012A4020, 0, 0, 1'b0, "post_rst_add", hit, ha, hp);
        chk("post_rst_add_len", hit, 3);

        for (int n = 0; n < 60; n++) begin
            int k, wf, wm;
            k = $urandom_range(0, 9);
            wf = k > 8 ? TO + $urandom_range(0, 1) : k % 4;
            k = $urandom_range(0, 9);
            wm = k > 8 ? TO + $urandom_range(0, 2) : k % 4;
            v = tv[$urandom_range(0, tv.size() - 1)];
            v.instr[25:6] = 20'($urandom);
            run_instr(v.instr, wf, wm, 1'($urandom), $sformatf("rnd%0d_%s", n, v.name), hit, ha, hp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
